// File: rtl/controlador_pilha_if.sv
// Request/response and memory-side signal bundle for the stack controller.
// The slave modport is the controller; the master modport is the requester plus the memory wrapper.
interface controlador_pilha_if #(
    parameter int unsigned Largura_da_pilha = 16,
    parameter int unsigned Tamanho_endereco = 6
);
    logic                        push;
    logic                        pop;
    logic [Largura_da_pilha-1:0] dado_in;
    logic [Largura_da_pilha-1:0] dado_out;
    logic                        dado_valido;
    logic                        pronto;
    logic                        cheia;
    logic                        vazia;
    logic                        erro;
    logic [Tamanho_endereco:0]   sp;
    logic [Tamanho_endereco-1:0] mem_endereco;
    logic                        mem_io;
    logic [Largura_da_pilha-1:0] mem_data_w;
    logic                        mem_data_oe;
    logic [Largura_da_pilha-1:0] mem_data_r;

    modport slave (
        input  push, pop, dado_in, mem_data_r,
        output dado_out, dado_valido, pronto, cheia, vazia, erro, sp,
               mem_endereco, mem_io, mem_data_w, mem_data_oe
    );

    modport master (
        output push, pop, dado_in, mem_data_r,
        input  dado_out, dado_valido, pronto, cheia, vazia, erro, sp,
               mem_endereco, mem_io, mem_data_w, mem_data_oe
    );
endinterface

// File: rtl/controlador_pilha.sv
// Push/pop sequencer for the Pilha stack memory: owns the stack pointer,
// issues one write cycle per push and a read + wait cycle per pop.
module controlador_pilha #(
    parameter int unsigned Largura_da_pilha = 16,
    parameter int unsigned Tamanho_da_pilha = 64,
    parameter int unsigned Tamanho_endereco = 6
) (
    input  logic               clk,
    input  logic               rst,
    controlador_pilha_if.slave bus
);
    localparam int unsigned W   = Largura_da_pilha;
    localparam int unsigned A   = Tamanho_endereco;
    localparam int unsigned SPW = Tamanho_endereco + 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESCRITA = 2'd1,
        LEITURA = 2'd2,
        ESPERA  = 2'd3
    } estado_t;

    estado_t        estado_q, estado_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [W-1:0]   dado_out_q, dado_out_d;
    logic [W-1:0]   mem_data_w_q, mem_data_w_d;
    logic [A-1:0]   mem_endereco_q, mem_endereco_d;
    logic           dado_valido_q, dado_valido_d;
    logic           erro_q, erro_d;

    logic           pronto_c, cheia_c, vazia_c, mem_io_c, mem_data_oe_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q       <= OCIOSO;
            sp_q           <= '0;
            dado_out_q     <= '0;
            mem_data_w_q   <= '0;
            mem_endereco_q <= '0;
            dado_valido_q  <= 1'b0;
            erro_q         <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            sp_q           <= sp_d;
            dado_out_q     <= dado_out_d;
            mem_data_w_q   <= mem_data_w_d;
            mem_endereco_q <= mem_endereco_d;
            dado_valido_q  <= dado_valido_d;
            erro_q         <= erro_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        estado_d       = estado_q;
        sp_d           = sp_q;
        dado_out_d     = dado_out_q;
        mem_data_w_d   = mem_data_w_q;
        mem_endereco_d = mem_endereco_q;
        dado_valido_d  = 1'b0;
        erro_d         = 1'b0;

        case (estado_q)
            OCIOSO: begin
                // Simultaneous push+pop, push on full and pop on empty are all rejected
                if (bus.push && bus.pop) begin
                    erro_d = 1'b1;
                end else if (bus.push) begin
                    if (cheia_c) begin
                        erro_d = 1'b1;
                    end else begin
                        estado_d       = ESCRITA;
                        mem_data_w_d   = bus.dado_in;
                        mem_endereco_d = sp_q[A-1:0];
                    end
                end else if (bus.pop) begin
                    if (vazia_c) begin
                        erro_d = 1'b1;
                    end else begin
                        estado_d       = LEITURA;
                        mem_endereco_d = A'(sp_q - SPW'(1));
                    end
                end
            end
            ESCRITA: begin
                sp_d     = sp_q + SPW'(1);
                estado_d = OCIOSO;
            end
            LEITURA: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                dado_out_d    = bus.mem_data_r;
                dado_valido_d = 1'b1;
                sp_d          = sp_q - SPW'(1);
                estado_d      = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Outputs decoded straight from the registers, so reset clears them without a clock
    always_comb begin
        pronto_c      = 1'b0;
        mem_io_c      = 1'b0;
        mem_data_oe_c = 1'b0;
        cheia_c       = (sp_q == SPW'(Tamanho_da_pilha));
        vazia_c       = (sp_q == '0);

        case (estado_q)
            OCIOSO:  pronto_c = 1'b1;
            ESCRITA: begin
                mem_io_c      = 1'b1;
                mem_data_oe_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.pronto       = pronto_c;
    assign bus.cheia        = cheia_c;
    assign bus.vazia        = vazia_c;
    assign bus.mem_io       = mem_io_c;
    assign bus.mem_data_oe  = mem_data_oe_c;
    assign bus.sp           = sp_q;
    assign bus.dado_out     = dado_out_q;
    assign bus.dado_valido  = dado_valido_q;
    assign bus.erro         = erro_q;
    assign bus.mem_endereco = mem_endereco_q;
    assign bus.mem_data_w   = mem_data_w_q;
endmodule

// File: tb/tb_controlador_pilha.sv
// Bench for controlador_pilha: directed vector table plus fill/drain, burst-push
// and reset-during-write sequences against a behavioural Pilha memory.
module tb_controlador_pilha;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    controlador_pilha_if #(.Largura_da_pilha(16), .Tamanho_endereco(6)) bus ();

    controlador_pilha dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pilha model behind the wrapper's tri-state Data bus
    wire  [15:0] data_bus;
    logic [15:0] mem [64];
    logic [15:0] rd_q;
    assign data_bus = bus.mem_data_oe ? bus.mem_data_w : 16'bz;
    always @(posedge clk) begin
        if (bus.mem_io) mem[bus.mem_endereco] <= data_bus;
        else            rd_q <= mem[bus.mem_endereco];
    end
    assign bus.mem_data_r = rd_q;

    typedef struct {
        logic        push;
        logic        pop;
        logic [15:0] din;
        logic        e_pronto;
        logic [6:0]  e_sp;
        logic        e_erro;
        logic        e_dv;
        logic [15:0] e_dout;
        logic        e_io;
        logic [5:0]  e_addr;
    } vec_t;

    vec_t        tab [23];
    logic [15:0] hist [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_pronto", 32'(bus.pronto), 32'd1);
        chk("rst_sp", 32'(bus.sp), 32'd0);
        chk("rst_vazia", 32'(bus.vazia), 32'd1);
        chk("rst_cheia", 32'(bus.cheia), 32'd0);
        chk("rst_erro", 32'(bus.erro), 32'd0);
        chk("rst_dado_valido", 32'(bus.dado_valido), 32'd0);
        chk("rst_mem_io", 32'(bus.mem_io), 32'd0);
        chk("rst_mem_data_oe", 32'(bus.mem_data_oe), 32'd0);
        chk("rst_mem_endereco", 32'(bus.mem_endereco), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_push(input logic [15:0] v, input logic [5:0] addr);
        @(negedge clk);
        bus.push    = 1'b1;
        bus.dado_in = v;
        @(posedge clk);
        #1;
        chk("push_mem_io", 32'(bus.mem_io), 32'd1);
        chk("push_addr", 32'(bus.mem_endereco), 32'(addr));
        @(negedge clk);
        bus.push = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_pop(input logic [15:0] exp);
        @(negedge clk);
        bus.pop = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.pop = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pop_valido", 32'(bus.dado_valido), 32'd1);
        chk("pop_dado", 32'(bus.dado_out), 32'(exp));
    endtask

    initial begin
        int n_io;
        int n_err;
        logic [15:0] v;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.dado_in = '0;

        //            push pop din       pronto sp    erro dv dout      io addr
        tab[0]  = '{1'b1, 1'b0, 16'h1234, 1'b0, 7'd0, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd0};
        tab[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd1, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd0};
        tab[2]  = '{1'b1, 1'b0, 16'hABCD, 1'b0, 7'd1, 1'b0, 1'b0, 16'h0000, 1'b1, 6'd1};
        tab[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd1};
        tab[4]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 7'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd1};
        tab[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 6'd1};
        tab[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd1, 1'b0, 1'b1, 16'hABCD, 1'b0, 6'd1};
        tab[7]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 7'd1, 1'b0, 1'b0, 16'hABCD, 1'b0, 6'd0};
        tab[8]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'd1, 1'b0, 1'b0, 16'hABCD, 1'b0, 6'd0};
        tab[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd0, 1'b0, 1'b1, 16'h1234, 1'b0, 6'd0};
        tab[10] = '{1'b0, 1'b1, 16'h0000, 1'b1, 7'd0, 1'b1, 1'b0, 16'h1234, 1'b0, 6'd0};
        tab[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd0, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd0};
        tab[12] = '{1'b1, 1'b0, 16'h0011, 1'b0, 7'd0, 1'b0, 1'b0, 16'h1234, 1'b1, 6'd0};
        tab[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd1, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd0};
        tab[14] = '{1'b1, 1'b0, 16'h0022, 1'b0, 7'd1, 1'b0, 1'b0, 16'h1234, 1'b1, 6'd1};
        tab[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd2, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd1};
        tab[16] = '{1'b1, 1'b0, 16'h0033, 1'b0, 7'd2, 1'b0, 1'b0, 16'h1234, 1'b1, 6'd2};
        tab[17] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd3, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd2};
        tab[18] = '{1'b1, 1'b1, 16'h00FF, 1'b1, 7'd3, 1'b1, 1'b0, 16'h1234, 1'b0, 6'd2};
        tab[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd3, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd2};
        tab[20] = '{1'b0, 1'b1, 16'h0000, 1'b0, 7'd3, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd2};
        tab[21] = '{1'b0, 1'b0, 16'h0000, 1'b0, 7'd3, 1'b0, 1'b0, 16'h1234, 1'b0, 6'd2};
        tab[22] = '{1'b0, 1'b0, 16'h0000, 1'b1, 7'd2, 1'b0, 1'b1, 16'h0033, 1'b0, 6'd2};

        // Reset values must appear before any clock edge
        #2;
        chk_reset_values();
        chk("rst_dado_out", 32'(bus.dado_out), 32'd0);
        chk("rst_mem_data_w", 32'(bus.mem_data_w), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            bus.push    = tab[i].push;
            bus.pop     = tab[i].pop;
            bus.dado_in = tab[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pronto", i), 32'(bus.pronto), 32'(tab[i].e_pronto));
            chk($sformatf("v%0d_sp", i), 32'(bus.sp), 32'(tab[i].e_sp));
            chk($sformatf("v%0d_erro", i), 32'(bus.erro), 32'(tab[i].e_erro));
            chk($sformatf("v%0d_dado_valido", i), 32'(bus.dado_valido), 32'(tab[i].e_dv));
            chk($sformatf("v%0d_dado_out", i), 32'(bus.dado_out), 32'(tab[i].e_dout));
            chk($sformatf("v%0d_mem_io", i), 32'(bus.mem_io), 32'(tab[i].e_io));
            chk($sformatf("v%0d_mem_data_oe", i), 32'(bus.mem_data_oe), 32'(tab[i].e_io));
            chk($sformatf("v%0d_mem_endereco", i), 32'(bus.mem_endereco), 32'(tab[i].e_addr));
            chk($sformatf("v%0d_vazia", i), 32'(bus.vazia), 32'(tab[i].e_sp == 7'd0));
            chk($sformatf("v%0d_cheia", i), 32'(bus.cheia), 32'(tab[i].e_sp == 7'd64));
        end
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop  = 1'b0;

        // Fill to 64, reject a 65th push, then drain in reverse order
        do_reset();
        for (int i = 0; i < 64; i++) begin
            v = 16'($urandom);
            hist.push_back(v);
            do_push(v, 6'(i));
        end
        chk("full_sp", 32'(bus.sp), 32'd64);
        chk("full_cheia", 32'(bus.cheia), 32'd1);
        @(negedge clk);
        bus.push    = 1'b1;
        bus.dado_in = 16'hDEAD;
        @(posedge clk);
        #1;
        chk("over_erro", 32'(bus.erro), 32'd1);
        chk("over_mem_io", 32'(bus.mem_io), 32'd0);
        chk("over_sp", 32'(bus.sp), 32'd64);
        chk("over_pronto", 32'(bus.pronto), 32'd1);
        @(negedge clk);
        bus.push = 1'b0;
        @(posedge clk);
        #1;
        chk("over_erro_clear", 32'(bus.erro), 32'd0);
        for (int i = 63; i >= 0; i--) do_pop(hist[i]);
        chk("drain_sp", 32'(bus.sp), 32'd0);
        chk("drain_vazia", 32'(bus.vazia), 32'd1);

        // Push held for 8 cycles: only every other edge is accepted
        do_reset();
        n_io  = 0;
        n_err = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.push    = 1'b1;
            bus.dado_in = 16'(k);
            @(posedge clk);
            #1;
            if (bus.mem_io) n_io++;
            if (bus.erro) n_err++;
        end
        @(negedge clk);
        bus.push = 1'b0;
        chk("burst_writes", 32'(n_io), 32'd4);
        chk("burst_erro", 32'(n_err), 32'd0);
        chk("burst_sp", 32'(bus.sp), 32'd4);
        for (int a = 0; a < 4; a++) chk($sformatf("burst_mem%0d", a), 32'(mem[a]), 32'(2 * a));

        // Reset in the middle of a write cycle
        do_reset();
        do_push(16'h0AAA, 6'd0);
        @(negedge clk);
        bus.push    = 1'b1;
        bus.dado_in = 16'h0BBB;
        @(posedge clk);
        #1;
        chk("midw_mem_io", 32'(bus.mem_io), 32'd1);
        bus.push = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_values();
        @(negedge clk);
        rst = 1'b0;
        do_push(16'h0055, 6'd0);
        chk("midw_sp_after_push", 32'(bus.sp), 32'd1);
        do_pop(16'h0055);
        chk("midw_sp_end", 32'(bus.sp), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
